// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-addressable data memory.
// Size codes follow the RISC-V funct3 load/store encoding.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << addr_lo;
            SZ_H, SZ_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] addr_lo,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    res = {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   res = {24'h0, sh[7:0]};
            SZ_H:    res = {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   res = {16'h0, sh[15:0]};
            SZ_W:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide RAM with per-byte write enables, one shared write/read port and an
// independent byte read port. Reads are combinational; the owner registers them.
module dmem_bank #(
    parameter int DEPTH_WORDS = 16,
    parameter int WAW         = 4,
    parameter int BAW         = 6
) (
    input  logic             clk,
    input  logic [WAW-1:0]   addr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    input  logic [BAW-1:0]   baddr_i,
    output logic [7:0]       bdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] bword;

    // NOTE: the array has no reset; a reset net to every bit would block RAM
    // inference, and the controller clears contents with its init sweep instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem[addr_i];
    assign bword   = mem[WAW'(baddr_i >> 2)];
    assign bdata_o = bword[{baddr_i[1:0], 3'b000} +: 8];

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: init sweep FSM, request error checks, one-cycle
// registered load/store responses and a registered display byte port.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_BYTES = 64,
    parameter int          ADDR_W      = 32,
    parameter int          DISP_AW     = 6,
    parameter logic [31:0] INIT_VALUE  = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_size,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    input  logic [DISP_AW-1:0] disp_addr,
    output logic [7:0]         disp_data,
    output logic               busy
);

    localparam int AW          = $clog2(DEPTH_BYTES);
    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int WAW         = (AW > 2) ? AW - 2 : 1;
    localparam logic [WAW-1:0]   LAST_WORD  = WAW'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam logic [DISP_AW:0] DISP_LIMIT = (DISP_AW + 1)'(DEPTH_BYTES);

    dmem_state_e    state_q, state_d;
    logic [WAW-1:0] init_ptr_q, init_ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic [7:0]     disp_data_q, disp_data_d;

    logic [WAW-1:0] bank_addr;
    logic [3:0]     bank_be;
    logic [31:0]    bank_wdata;
    logic [31:0]    bank_rdata;
    logic [7:0]     bank_bdata;

    logic           accept;
    logic           req_illegal, req_misaligned, req_oor, req_err;
    logic [WAW-1:0] req_word;

    assign accept   = req_valid && (state_q == READY);
    assign req_word = WAW'(req_addr[AW-1:0] >> 2);
    // Range uses every address bit so high aliases of valid offsets are still rejected.
    assign req_oor  = {1'b0, req_addr} >= ADDR_LIMIT;
    assign req_err  = req_illegal || req_misaligned || req_oor;

    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_size)
            SZ_B, SZ_H, SZ_W: req_illegal = 1'b0;
            SZ_BU, SZ_HU:     req_illegal = req_we;
            default:          req_illegal = 1'b1;
        endcase
        case (req_size)
            SZ_H, SZ_HU: req_misaligned = req_addr[0];
            SZ_W:        req_misaligned = |req_addr[1:0];
            default:     req_misaligned = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        bank_addr  = req_word;
        bank_be    = 4'b0000;
        bank_wdata = store_lanes(req_size, req_wdata);
        case (state_q)
            INIT: begin
                bank_addr  = init_ptr_q;
                bank_be    = 4'b1111;
                bank_wdata = INIT_VALUE;
                if (init_ptr_q == LAST_WORD) begin
                    state_d    = READY;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            READY: begin
                if (accept && req_we && !req_err) begin
                    bank_be = byte_en(req_size, req_addr[1:0]);
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && req_err;
        rsp_rdata_d = (accept && !req_err && !req_we)
                    ? load_extend(req_size, req_addr[1:0], bank_rdata) : 32'h0;
        disp_data_d = ({1'b0, disp_addr} < DISP_LIMIT) ? bank_bdata : 8'h00;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            disp_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            disp_data_q <= disp_data_d;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAW         (WAW),
        .BAW         (AW)
    ) u_bank (
        .clk     (clk),
        .addr_i  (bank_addr),
        .be_i    (bank_be),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata),
        .baddr_i (disp_addr[AW-1:0]),
        .bdata_o (bank_bdata)
    );

    assign req_ready = (state_q == READY);
    assign busy      = (state_q == INIT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign disp_data = disp_data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus a random
// legal request stream checked against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int          DEPTH   = 64;
    localparam int          ADDR_W  = 32;
    localparam int          DISP_AW = 6;
    localparam logic [31:0] INIT_V  = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [5:0]  disp_addr;
    logic [7:0]  disp_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (ADDR_W),
        .DISP_AW     (DISP_AW),
        .INIT_VALUE  (INIT_V)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .busy      (busy)
    );

    task automatic model_init();
        logic [31:0] iv;
        iv = INIT_V;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(iv >> (8 * (i % 4)));
    endtask

    task automatic model_store(input logic [2:0] size, input int a, input logic [31:0] wd);
        int n;
        n = (size == 3'b000) ? 1 : (size == 3'b001) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(wd >> (8 * k));
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] size, input int a);
        int v;
        case (size)
            3'b000, 3'b100: v = int'(ref_mem[a]);
            3'b001, 3'b101: v = int'(ref_mem[a]) + 256 * int'(ref_mem[a + 1]);
            default: return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
        endcase
        if (size == 3'b000 && v >= 128)   v = v - 256;
        if (size == 3'b001 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    // Drives one request for exactly one clock edge and samples the response after it.
    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [33:0] rsp);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        rsp       = {rsp_valid, rsp_err, rsp_rdata};
        req_valid = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic [33:0] r;
        n_cmp++;
        if ({busy, req_ready, rsp_valid, rsp_err, rsp_rdata, disp_data} !== {4'b1000, 32'h0, 8'h0}) begin
            n_bad++;
            $display("FAIL reset_values: got busy=%b ready=%b vld=%b err=%b rd=%h disp=%h want 1 0 0 0 0 0",
                     busy, req_ready, rsp_valid, rsp_err, rsp_rdata, disp_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
        count_busy(cnt);
        n_cmp++;
        if (cnt !== DEPTH / 4) begin
            n_bad++;
            $display("FAIL init_cycles: got %0d want %0d", cnt, DEPTH / 4);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_init: got %b want 1", req_ready);
        end
        issue(1'b0, 3'b010, 32'h3c, 32'h0, r);
        n_cmp++;
        if (r !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL lw_after_init: got %h want %h", r, {2'b10, 32'h0});
        end
    endtask

    task automatic test_load_ext();
        logic [33:0] r;
        logic [2:0]  sz [5];
        logic [31:0] ad [5];
        logic [31:0] ex [5];
        sz = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ad = '{32'h10, 32'h13, 32'h12, 32'h12, 32'h10};
        ex = '{32'h0000000d, 32'h0000008b, 32'hffff8bad, 32'h00008bad, 32'h8badf00d};
        issue(1'b1, 3'b010, 32'h10, 32'h8badf00d, r);
        model_store(3'b010, 'h10, 32'h8badf00d);
        n_cmp++;
        if (r !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL sw_rsp: got %h want %h", r, {2'b10, 32'h0});
        end
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], ad[i], 32'h0, r);
            n_cmp++;
            if (r !== {2'b10, ex[i]}) begin
                n_bad++;
                $display("FAIL load_ext[%0d]: got %h want %h", i, r, {2'b10, ex[i]});
            end
        end
    endtask

    task automatic test_errors();
        logic [33:0] r;
        logic        we [7];
        logic [2:0]  sz [7];
        logic [31:0] ad [7];
        logic [31:0] wd [7];
        we = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        sz = '{3'b001, 3'b010, 3'b000, 3'b011, 3'b100, 3'b010, 3'b000};
        ad = '{32'h21, 32'h22, 32'h40, 32'h20, 32'h20, 32'h44, 32'h80000020};
        wd = '{32'h1234, 32'hcafebabe, 32'h0, 32'h0, 32'hcafebabe, 32'hcafebabe, 32'hcafebabe};
        issue(1'b1, 3'b010, 32'h20, 32'h11223344, r);
        issue(1'b1, 3'b010, 32'h04, 32'h55667788, r);
        model_store(3'b010, 'h20, 32'h11223344);
        model_store(3'b010, 'h04, 32'h55667788);
        for (int i = 0; i < 7; i++) begin
            issue(we[i], sz[i], ad[i], wd[i], r);
            n_cmp++;
            if (r !== {2'b11, 32'h0}) begin
                n_bad++;
                $display("FAIL err_rsp[%0d]: got %h want %h", i, r, {2'b11, 32'h0});
            end
        end
        issue(1'b0, 3'b010, 32'h20, 32'h0, r);
        n_cmp++;
        if (r !== {2'b10, 32'h11223344}) begin
            n_bad++;
            $display("FAIL err_no_write_20: got %h want %h", r, {2'b10, 32'h11223344});
        end
        issue(1'b0, 3'b010, 32'h04, 32'h0, r);
        n_cmp++;
        if (r !== {2'b10, 32'h55667788}) begin
            n_bad++;
            $display("FAIL err_no_write_04: got %h want %h", r, {2'b10, 32'h55667788});
        end
    endtask

    task automatic test_display();
        logic [33:0] r;
        issue(1'b1, 3'b000, 32'h5, 32'h55, r);
        model_store(3'b000, 5, 32'h55);
        disp_addr = 6'd5;
        issue(1'b1, 3'b000, 32'h5, 32'hAA, r);
        model_store(3'b000, 5, 32'hAA);
        n_cmp++;
        if (r !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL disp_sb_rsp: got %h want %h", r, {2'b10, 32'h0});
        end
        n_cmp++;
        if (disp_data !== 8'h55) begin
            n_bad++;
            $display("FAIL disp_old: got %h want 55", disp_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (disp_data !== 8'hAA) begin
            n_bad++;
            $display("FAIL disp_new: got %h want aa", disp_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] r;
        logic [31:0] exp_w;
        int cnt;
        int stray;
        exp_w = model_load(3'b010, 'h10);
        issue(1'b0, 3'b010, 32'h10, 32'h0, r);
        n_cmp++;
        if (r !== {2'b10, exp_w}) begin
            n_bad++;
            $display("FAIL pre_reset_load: got %h want %h", r, {2'b10, exp_w});
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h10;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, busy, req_ready} !== 3'b010) begin
            n_bad++;
            $display("FAIL async_reset: got vld/busy/ready=%b want 010", {rsp_valid, busy, req_ready});
        end
        stray = 0;
        @(posedge clk);
        #1;
        if (rsp_valid !== 1'b0) stray++;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) stray++;
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_init();
        count_busy(cnt);
        if (rsp_valid !== 1'b0) stray++;
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL stray_rsp_valid: got %0d pulses want 0", stray);
        end
        n_cmp++;
        if (cnt !== DEPTH / 4) begin
            n_bad++;
            $display("FAIL reinit_cycles: got %0d want %0d", cnt, DEPTH / 4);
        end
        exp_w = model_load(3'b010, 'h10);
        issue(1'b0, 3'b010, 32'h10, 32'h0, r);
        n_cmp++;
        if (r !== {2'b10, exp_w}) begin
            n_bad++;
            $display("FAIL cleared_after_reinit: got %h want %h", r, {2'b10, exp_w});
        end
    endtask

    task automatic test_random();
        int acc;
        int rsps;
        logic [2:0] ld_sz [5];
        logic [2:0] st_sz [3];
        ld_sz = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_sz = '{3'b000, 3'b001, 3'b010};
        acc  = 0;
        rsps = 0;
        for (int i = 0; i < 10000; i++) begin
            logic        v;
            logic        we;
            logic [2:0]  sz;
            int          a;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            logic [7:0]  exp_disp;
            v  = ($urandom_range(0, 7) != 0);
            we = 1'($urandom_range(0, 1));
            wd = $urandom();
            sz = we ? st_sz[$urandom_range(0, 2)] : ld_sz[$urandom_range(0, 4)];
            a  = $urandom_range(0, DEPTH - 1);
            if (sz[1:0] == 2'b01) a = a & ~1;
            else if (sz == 3'b010) a = a & ~3;
            disp_addr = 6'($urandom_range(0, DEPTH - 1));
            exp_disp  = ref_mem[disp_addr];
            exp_rd    = 32'h0;
            if (v) begin
                acc++;
                if (we) model_store(sz, a, wd);
                else    exp_rd = model_load(sz, a);
            end
            req_valid = v;
            req_we    = we;
            req_size  = sz;
            req_addr  = 32'(a);
            req_wdata = wd;
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) rsps++;
            n_cmp++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {v, 1'b0, exp_rd}) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: got %h want %h (we=%b sz=%b a=%0h)",
                         i, {rsp_valid, rsp_err, rsp_rdata}, {v, 1'b0, exp_rd}, we, sz, a);
            end
            n_cmp++;
            if (disp_data !== exp_disp) begin
                n_bad++;
                $display("FAIL rand_disp[%0d]: got %h want %h (addr %0d)", i, disp_data, exp_disp, disp_addr);
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) rsps++;
        n_cmp++;
        if (rsps !== acc) begin
            n_bad++;
            $display("FAIL rsp_count: got %0d want %0d", rsps, acc);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        disp_addr = 6'd0;
        #12;
        test_reset();
        test_load_ext();
        test_errors();
        test_display();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised byte-addressable data memory for the single-cycle/pipelined core. Successor to the fixed 21-byte data memory.
- Little-endian word storage with a valid/ready request channel, 1-cycle registered read latency, and signed/unsigned loads.
- Flags misaligned, out-of-range and illegal accesses.
- Self-clears after reset via an init state machine.
- Has an independent display read port for the VGA block.

Parameters:
- DEPTH_BYTES, 64, memory size in bytes; multiple of 4, minimum 4.
- ADDR_W, 32, request address width.
- DISP_AW, 6, display port address width; must cover DEPTH_BYTES.
- INIT_VALUE, 32'h0, word written to every location during init.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (funct3 encoding).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes used for B/H.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  accepted request was misaligned, out of range or illegal.
- disp_addr  in  DISP_AW  display byte address.
- disp_data  out  8  registered byte at disp_addr.
- busy  out  1  high while initialising.

Behaviour:
- Reset values (async, rst_n low): state = INIT, init_ptr = 0, req_ready = 0, busy = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, disp_data = 0. The array itself is not reset.
- State INIT:
  - Writes INIT_VALUE to word init_ptr each cycle; init_ptr increments.
  - After word DEPTH_BYTES/4-1 is written, moves to READY next cycle. Init takes exactly DEPTH_BYTES/4 cycles.
  - req_ready = 0 throughout.
  - disp_data still updates and may show pre-init contents.
- State READY:
  - req_ready = 1 and busy = 0 continuously. There is no response backpressure.
  - Throughput is one request per cycle.
- Reset mid-operation: any state returns to INIT and restarts at word 0. A pending rsp_valid is dropped.
- Error check, on the accepted cycle:
  - Illegal: size 011, 110, 111; or size 100/101 with req_we = 1.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Out of range: addr >= DEPTH_BYTES. Aligned accesses cannot straddle the end.
  - Error → no array write; next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Store, accepted at cycle n:
  - Byte enables come from size and addr[1:0]. The array is written at edge n.
  - rsp_valid = 1, rsp_err = 0, rsp_rdata = 0 in cycle n+1.
- Load, accepted at cycle n:
  - rsp_rdata is valid in cycle n+1.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is {b3,b2,b1,b0}.
- Back-to-back: a load in cycle n+1 to an address stored in cycle n returns the new data. No forwarding is needed because the write completes at edge n.
- Display port:
  - disp_data <= byte[disp_addr] every cycle, 1-cycle latency.
  - disp_addr >= DEPTH_BYTES returns 0.
  - A simultaneous store to the same byte gives the display the old value (read-before-write).
- Widths:
  - Only addr bits [$clog2(DEPTH_BYTES)-1:0] index the array.
  - The range check uses the full ADDR_W bits.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum mem_size_e (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - typedef enum dmem_state_e {INIT, READY}.
  - Function byte_en(size, addr_lo) returning 4-bit enables.
  - Function load_extend(size, addr_lo, word) returning 32 bits.
- One sub-module, dmem_bank: a word-wide RAM with 4 byte-write enables, one write/read port and one byte read port, no reset.
- FSM, error check and response registers live in data_memory_ctrl.

Test Plan:
- Release rst_n with DEPTH_BYTES = 64 → busy high exactly 16 cycles, req_ready rises on cycle 16; LW 0x3C then returns 0x00000000.
- SW 0x8badf00d @0x10, then LB 0x10, LBU 0x13, LH 0x12, LHU 0x12, LW 0x10 back-to-back:
  - Each rsp one cycle after its request.
  - Expected: 0x0000000d, 0x0000008b, 0xffff8bad, 0x00008bad, 0x8badf00d.
- SH 0x1234 @0x21, SW @0x22, LB @0x40, size 011, SB with size 100 → rsp_err = 1 and rsp_rdata = 0 for each; a following LW 0x20 returns unchanged contents.
- Display: SB 0xAA @5 with disp_addr = 5 in the same cycle → disp_data = old value next cycle, then 0xAA the cycle after.
- Pulse rst_n low during a load acceptance and during INIT (word 7) → rsp_valid never pulses; init restarts at word 0 and busy again lasts 16 cycles.
- Random legal stream against a byte-array reference model, 10k requests → every rsp_rdata matches and rsp_valid count equals accepted count.
